// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared types and constants for the locker latch controller
// Contents: lock_state_t FSM encoding, DRIVE_SET/DRIVE_RST latch drive
//           directions, DEFAULT_CODE loaded into the code register at reset.
package lock_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    CHK     = 3'd2,
    DRIVE   = 3'd3,
    LOCKOUT = 3'd4,
    PROG    = 3'd5,
    COMMIT  = 3'd6
  } lock_state_t;

  // Direction of a latch drive: SET unlocks (Q=1), RST locks (Q=0).
  localparam logic DRIVE_SET = 1'b1;
  localparam logic DRIVE_RST = 1'b0;

  localparam logic [15:0] DEFAULT_CODE = 16'h1234;

endpackage

// File: rtl/lock_ctrl_if.sv
// rtl/lock_ctrl_if.sv - keypad/request/latch bundle between keypad side and lock_ctrl
// Signals: key_valid/key_digit/key_enter/key_clear keypad strobes,
//          lock_req/prog_req requests, latch_q latch feedback,
//          latch_s/latch_r/latch_en latch drive, busy/lockout/fail_cnt status.
// Modports: master = keypad and latch side, slave = lock_ctrl.
interface lock_ctrl_if #(
  parameter int DW = 4,
  parameter int FW = 2
);

  logic          key_valid;
  logic [DW-1:0] key_digit;
  logic          key_enter;
  logic          key_clear;
  logic          lock_req;
  logic          prog_req;
  logic          latch_q;
  logic          latch_s;
  logic          latch_r;
  logic          latch_en;
  logic          busy;
  logic          lockout;
  logic [FW-1:0] fail_cnt;

  modport master (
    output key_valid, key_digit, key_enter, key_clear, lock_req, prog_req, latch_q,
    input  latch_s, latch_r, latch_en, busy, lockout, fail_cnt
  );

  modport slave (
    input  key_valid, key_digit, key_enter, key_clear, lock_req, prog_req, latch_q,
    output latch_s, latch_r, latch_en, busy, lockout, fail_cnt
  );

endinterface

// File: rtl/latch_pulser.sv
// rtl/latch_pulser.sv - setup/pulse/hold drive sequencer for the gated RS latch
// Ports: clk, rst_n (sync, active-low); start + dir request one drive;
//        s/r/en registered latch inputs; done high during the hold cycle.
module latch_pulser #(
  parameter int EN_CYC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic dir,
  output logic s,
  output logic r,
  output logic en,
  output logic done
);

  import lock_pkg::*;

  localparam int PW = $clog2(EN_CYC + 2);
  localparam logic [PW-1:0] PULSE_END = PW'(EN_CYC);
  localparam logic [PW-1:0] HOLD_IDX  = PW'(EN_CYC + 1);

  logic          active_q;
  logic [PW-1:0] ph_q;
  logic          s_q;
  logic          r_q;
  logic          en_q;

  // ph_q: 0 = setup, 1..EN_CYC = enable pulse, EN_CYC+1 = hold.
  // S and R both come from the single dir bit so they can never be high together,
  // and en is additionally gated on exactly one of them being asserted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      ph_q     <= '0;
      s_q      <= 1'b0;
      r_q      <= 1'b0;
      en_q     <= 1'b0;
    end else if (!active_q) begin
      if (start) begin
        active_q <= 1'b1;
        ph_q     <= '0;
        s_q      <= (dir == DRIVE_SET);
        r_q      <= (dir == DRIVE_RST);
        en_q     <= 1'b0;
      end
    end else if (ph_q == HOLD_IDX) begin
      active_q <= 1'b0;
      ph_q     <= '0;
      s_q      <= 1'b0;
      r_q      <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      ph_q <= ph_q + 1'b1;
      en_q <= (ph_q < PULSE_END) && (s_q ^ r_q);
    end
  end

  assign s    = s_q;
  assign r    = r_q;
  assign en   = en_q;
  assign done = active_q && (ph_q == HOLD_IDX);

endmodule

// File: rtl/lock_ctrl.sv
// rtl/lock_ctrl.sv - keypad code check, lockout and reprogramming controller for the lock latch
// Ports: C clock, rst_n sync active-low reset, io (lock_ctrl_if.slave):
//        keypad strobes and requests in, latch_q feedback in,
//        latch_s/latch_r/latch_en, busy, lockout, fail_cnt out (all registered).
module lock_ctrl #(
  parameter int DIGITS      = 4,
  parameter int DW          = 4,
  parameter int MAX_FAIL    = 3,
  parameter int LOCKOUT_CYC = 1000,
  parameter int EN_CYC      = 2,
  parameter logic [DIGITS*DW-1:0] DEFAULT_CODE = lock_pkg::DEFAULT_CODE
) (
  input  logic          C,
  input  logic          rst_n,
  lock_ctrl_if.slave    io
);

  import lock_pkg::*;

  localparam int CW = DIGITS * DW;
  localparam int NW = $clog2(DIGITS + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int LW = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;

  localparam logic [NW-1:0] FULL      = NW'(DIGITS);
  localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAIL);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCKOUT_CYC - 1);

  lock_state_t   state_q;
  lock_state_t   state_d;

  logic [CW-1:0] entry_q;
  logic [CW-1:0] code_q;
  logic [NW-1:0] cnt_q;
  logic [FW-1:0] fail_q;
  logic [LW-1:0] lk_cnt_q;
  logic          lock_pend_q;
  logic          busy_q;
  logic          lockout_q;

  logic          entry_clr;
  logic          entry_shift;
  logic          code_load;
  logic          fail_clr;
  logic          fail_inc;
  logic          pend_set;
  logic          drv_start;
  logic          drv_dir;
  logic          drv_done;
  logic          match;
  logic [FW-1:0] fail_inc_v;

  assign match      = (cnt_q == FULL) && (entry_q == code_q);
  assign fail_inc_v = (fail_q == FAIL_MAX) ? fail_q : fail_q + 1'b1;

  always_ff @(posedge C) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Keypad priority inside each accepting state: clear, then enter, then digit.
  always_comb begin
    state_d     = state_q;
    entry_clr   = 1'b0;
    entry_shift = 1'b0;
    code_load   = 1'b0;
    fail_clr    = 1'b0;
    fail_inc    = 1'b0;
    pend_set    = 1'b0;
    drv_start   = 1'b0;
    drv_dir     = DRIVE_RST;
    case (state_q)
      IDLE: begin
        if (io.lock_req) begin
          drv_start = 1'b1;
          drv_dir   = DRIVE_RST;
          state_d   = DRIVE;
        end else if (io.prog_req && io.latch_q) begin
          entry_clr = 1'b1;
          state_d   = PROG;
        end else if (io.key_clear) begin
          entry_clr = 1'b1;
        end else if (io.key_enter) begin
          state_d = IDLE;
        end else if (io.key_valid) begin
          entry_shift = 1'b1;
          state_d     = ENTRY;
        end
      end
      ENTRY: begin
        if (io.key_clear) begin
          entry_clr = 1'b1;
          state_d   = IDLE;
        end else if (io.key_enter) begin
          state_d = CHK;
        end else if (io.key_valid) begin
          entry_shift = 1'b1;
        end
      end
      CHK: begin
        entry_clr = 1'b1;
        drv_start = 1'b1;
        state_d   = DRIVE;
        if (match) begin
          fail_clr = 1'b1;
          drv_dir  = DRIVE_SET;
        end else begin
          fail_inc = 1'b1;
          drv_dir  = DRIVE_RST;
          pend_set = (fail_inc_v == FAIL_MAX);
        end
      end
      DRIVE: begin
        if (drv_done) begin
          state_d = lock_pend_q ? LOCKOUT : IDLE;
        end
      end
      LOCKOUT: begin
        if (lk_cnt_q == LOCK_LAST) begin
          fail_clr = 1'b1;
          state_d  = IDLE;
        end
      end
      PROG: begin
        if (io.key_clear) begin
          entry_clr = 1'b1;
          state_d   = IDLE;
        end else if (io.key_enter) begin
          // A short entry is not committed; the key press is simply consumed.
          if (cnt_q == FULL) begin
            state_d = COMMIT;
          end
        end else if (io.key_valid) begin
          entry_shift = 1'b1;
        end
      end
      COMMIT: begin
        code_load = 1'b1;
        entry_clr = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge C) begin
    if (!rst_n) begin
      entry_q     <= '0;
      cnt_q       <= '0;
      code_q      <= DEFAULT_CODE;
      fail_q      <= '0;
      lk_cnt_q    <= '0;
      lock_pend_q <= 1'b0;
      busy_q      <= 1'b0;
      lockout_q   <= 1'b0;
    end else begin
      // Status flags follow the next state so they line up with the state register.
      busy_q    <= (state_d == CHK) || (state_d == DRIVE) || (state_d == LOCKOUT);
      lockout_q <= (state_d == LOCKOUT);

      if (code_load) begin
        code_q <= entry_q;
      end

      if (entry_clr) begin
        entry_q <= '0;
        cnt_q   <= '0;
      end else if (entry_shift && (cnt_q != FULL)) begin
        entry_q <= {entry_q[CW-DW-1:0], io.key_digit};
        cnt_q   <= cnt_q + 1'b1;
      end

      if (fail_clr) begin
        fail_q <= '0;
      end else if (fail_inc) begin
        fail_q <= fail_inc_v;
      end

      // Remember at drive start whether this drive ends in lockout.
      if (drv_start) begin
        lock_pend_q <= pend_set;
      end

      if ((state_q == LOCKOUT) && (state_d == LOCKOUT)) begin
        lk_cnt_q <= lk_cnt_q + 1'b1;
      end else begin
        lk_cnt_q <= '0;
      end
    end
  end

  latch_pulser #(
    .EN_CYC (EN_CYC)
  ) u_pulser (
    .clk   (C),
    .rst_n (rst_n),
    .start (drv_start),
    .dir   (drv_dir),
    .s     (io.latch_s),
    .r     (io.latch_r),
    .en    (io.latch_en),
    .done  (drv_done)
  );

  assign io.busy     = busy_q;
  assign io.lockout  = lockout_q;
  assign io.fail_cnt = fail_q;

endmodule

// File: tb/tb_lock_ctrl.sv
// tb/tb_lock_ctrl.sv - directed scoreboard bench for lock_ctrl with a behavioural RS latch
module tb_lock_ctrl;

  localparam int EN_CYC = 2;

  typedef struct {
    logic dir;
    int   start;
    int   en_first;
    int   en_last;
    int   stop;
  } drv_t;

  logic clk = 1'b0;
  logic rst_n;
  logic q_model = 1'b0;
  int   cyc = 0;
  int   compared = 0;
  int   mism = 0;
  int   viol = 0;
  int   lock_cyc = 0;

  drv_t exp_q[$];
  drv_t obs_q[$];

  lock_ctrl_if #(.DW(4), .FW(2)) io ();

  lock_ctrl #(
    .DIGITS      (4),
    .DW          (4),
    .MAX_FAIL    (3),
    .LOCKOUT_CYC (1000),
    .EN_CYC      (EN_CYC),
    .DEFAULT_CODE(16'h1234)
  ) dut (
    .C     (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Gated RS latch: transparent while en is high.
  always @(posedge clk) begin
    if (io.latch_en) begin
      if (io.latch_s) q_model <= 1'b1;
      else if (io.latch_r) q_model <= 1'b0;
    end
  end
  assign io.latch_q = q_model;

  // Drive monitor: one record per contiguous S or R window, times as sampling edges.
  initial begin
    drv_t cur;
    logic in_drv;
    in_drv = 1'b0;
    cur = '{dir: 1'b0, start: 0, en_first: -1, en_last: -1, stop: 0};
    forever begin
      @(negedge clk);
      if (io.latch_s && io.latch_r) viol++;
      if (io.latch_en && !(io.latch_s ^ io.latch_r)) viol++;
      if (io.lockout) lock_cyc++;
      if (io.latch_s || io.latch_r) begin
        if (!in_drv) begin
          in_drv       = 1'b1;
          cur.dir      = io.latch_s;
          cur.start    = cyc + 1;
          cur.en_first = -1;
          cur.en_last  = -1;
        end
        if (io.latch_s !== cur.dir) viol++;
        if (io.latch_en) begin
          if (cur.en_first < 0) cur.en_first = cyc + 1;
          cur.en_last = cyc + 1;
        end
        cur.stop = cyc + 1;
      end else if (in_drv) begin
        in_drv = 1'b0;
        obs_q.push_back(cur);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    compared++;
    assert (o === e) else begin
      mism++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic press(input logic kv, input logic [3:0] d, input logic ke, input logic kc);
    @(negedge clk);
    io.key_valid = kv;
    io.key_digit = d;
    io.key_enter = ke;
    io.key_clear = kc;
    @(negedge clk);
    io.key_valid = 1'b0;
    io.key_digit = 4'h0;
    io.key_enter = 1'b0;
    io.key_clear = 1'b0;
  endtask

  task automatic enter_digits(input logic [15:0] c, input int n);
    for (int i = 0; i < n; i++) press(1'b1, c[15-4*i -: 4], 1'b0, 1'b0);
  endtask

  task automatic push_exp(input logic dir, input int s0);
    drv_t e;
    e.dir      = dir;
    e.start    = s0;
    e.en_first = s0 + 1;
    e.en_last  = s0 + EN_CYC;
    e.stop     = s0 + 1 + EN_CYC;
    exp_q.push_back(e);
  endtask

  task automatic check_drive();
    drv_t o;
    drv_t e;
    for (int i = 0; i < 60 && obs_q.size() == 0; i++) @(negedge clk);
    check("drive_seen", 32'(obs_q.size() != 0), 1);
    if (obs_q.size() != 0 && exp_q.size() != 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check("drv_dir", o.dir, e.dir);
      check("drv_start", o.start, e.start);
      check("drv_en_first", o.en_first, e.en_first);
      check("drv_en_last", o.en_last, e.en_last);
      check("drv_stop", o.stop, e.stop);
    end
  endtask

  // Digits then enter; expected drive begins two sampling edges after the enter edge.
  task automatic submit(input logic [15:0] c, input int n, input logic dir);
    int k;
    enter_digits(c, n);
    @(negedge clk);
    io.key_enter = 1'b1;
    k = cyc + 1;
    push_exp(dir, k + 2);
    @(negedge clk);
    io.key_enter = 1'b0;
    check("busy_rise", io.busy, 1);
    check_drive();
  endtask

  initial begin
    int k;
    drv_t o;
    rst_n        = 1'b0;
    io.key_valid = 1'b0;
    io.key_digit = 4'h0;
    io.key_enter = 1'b0;
    io.key_clear = 1'b0;
    io.lock_req  = 1'b0;
    io.prog_req  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_s", io.latch_s, 0);
    check("rst_r", io.latch_r, 0);
    check("rst_en", io.latch_en, 0);
    check("rst_busy", io.busy, 0);
    check("rst_lockout", io.lockout, 0);
    check("rst_fail", io.fail_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Default code unlocks.
    submit(16'h1234, 4, 1'b1);
    check("unlock_fail", io.fail_cnt, 0);
    check("unlock_q", q_model, 1);
    check("unlock_idle", io.busy, 0);

    // Reprogram while unlocked.
    @(negedge clk); io.prog_req = 1'b1;
    @(negedge clk); io.prog_req = 1'b0;
    enter_digits(16'h9876, 4);
    press(1'b0, 4'h0, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check("prog_no_drive", obs_q.size(), 0);
    check("prog_idle", io.busy, 0);
    check("prog_code", dut.code_q, 16'h9876);
    submit(16'h1234, 4, 1'b0);
    check("old_code_fail", io.fail_cnt, 1);
    check("old_code_q", q_model, 0);
    submit(16'h9876, 4, 1'b1);
    check("new_code_fail", io.fail_cnt, 0);
    check("new_code_q", q_model, 1);

    // Three failures lead to lockout.
    submit(16'h1235, 4, 1'b0);
    check("fail1", io.fail_cnt, 1);
    check("fail1_idle", io.busy, 0);
    submit(16'h1235, 4, 1'b0);
    check("fail2", io.fail_cnt, 2);
    submit(16'h1235, 4, 1'b0);
    check("fail3", io.fail_cnt, 3);
    check("lockout_on", io.lockout, 1);
    check("lockout_busy", io.busy, 1);
    enter_digits(16'h9876, 4);
    press(1'b0, 4'h0, 1'b1, 1'b0);
    @(negedge clk); io.lock_req = 1'b1;
    @(negedge clk); io.lock_req = 1'b0;
    for (int i = 0; i < 1200 && io.lockout; i++) @(negedge clk);
    check("lockout_end", io.lockout, 0);
    check("lockout_len", lock_cyc, 1000);
    check("lockout_fail_clr", io.fail_cnt, 0);
    check("lockout_idle", io.busy, 0);
    check("lockout_no_drive", obs_q.size(), 0);
    check("lockout_q", q_model, 0);

    // Clear beats digit and returns to IDLE; enter in IDLE does nothing.
    press(1'b1, 4'h9, 1'b0, 1'b0);
    press(1'b1, 4'h5, 1'b0, 1'b1);
    press(1'b0, 4'h0, 1'b1, 1'b0);
    repeat (6) @(negedge clk);
    check("clear_no_drive", obs_q.size(), 0);
    check("clear_idle", io.busy, 0);
    submit(16'h9870, 3, 1'b0);
    check("short_fail", io.fail_cnt, 1);
    submit(16'h9876, 4, 1'b1);
    check("relearn_fail", io.fail_cnt, 0);
    check("relearn_q", q_model, 1);

    // Relock request: drive starts one edge earlier than a keyed drive.
    @(negedge clk);
    io.lock_req = 1'b1;
    k = cyc + 1;
    push_exp(1'b0, k + 1);
    @(negedge clk);
    io.lock_req = 1'b0;
    check("lockreq_busy", io.busy, 1);
    check_drive();
    check("lockreq_q", q_model, 0);

    // Reset during the enable pulse.
    enter_digits(16'h9876, 4);
    press(1'b0, 4'h0, 1'b1, 1'b0);
    for (int i = 0; i < 20 && !io.latch_en; i++) @(negedge clk);
    check("pre_rst_en", io.latch_en, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_s", io.latch_s, 0);
    check("mid_rst_r", io.latch_r, 0);
    check("mid_rst_en", io.latch_en, 0);
    check("mid_rst_busy", io.busy, 0);
    check("mid_rst_code", dut.code_q, 16'h1234);
    rst_n = 1'b1;
    @(negedge clk);
    check("trunc_seen", 32'(obs_q.size() != 0), 1);
    if (obs_q.size() != 0) begin
      o = obs_q.pop_front();
      check("trunc_dir", o.dir, 1);
    end
    submit(16'h1234, 4, 1'b1);
    check("post_rst_fail", io.fail_cnt, 0);
    check("post_rst_q", q_model, 1);

    check("sr_invariant", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
